serial_tx: RTL and testbench

- Asynchronous-serial transmitter. Accepts parallel words over a valid/ready handshake and drives them onto a single line as start bit, data LSB first, optional parity, then stop bit.
- Counterpart of the team's serial receiver; the two are paired in the Verilog port/elaboration regression benches.
- Holds one word in a buffer while a frame shifts, so back-to-back frames have no idle gap.

---
 rtl/serial_tx_pkg.sv | 16 +
 rtl/serial_baud_gen.sv | 42 ++++
 rtl/serial_tx.sv | 172 +++++++++++++++++
 tb/tb_serial_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter and its baud generator.
//   state_e   : frame state encoding, also used by the matching receiver
//   LINE_IDLE : level the serial line rests at between frames
package serial_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_baud_gen.sv
// Bit-period counter shared by the serial transmitter and receiver.
// Counts 0..DIV-1 while enabled and pulses tick_o on the DIV-1 cycle.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clr_i  : restart the count at 0 on the next edge (wins over en_i)
//   en_i   : advance the count
//   tick_o : high for one cycle when the count is at DIV-1 and enabled
module serial_baud_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Asynchronous-serial transmitter: start bit, WIDTH data bits LSB first,
// optional parity bit, stop bit. One word can wait in a buffer while a
// frame is shifting so consecutive frames follow with no idle gap.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   data_i  : word to send, sampled only when accepted
//   valid_i : data_i is valid
//   ready_o : a word can be accepted (buffer empty), registered
//   tx_o    : serial line, idle high
//   busy_o  : a frame is in flight
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIV        = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             tx_o,
    output logic             busy_o
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic ODD_BIT = (PARITY_ODD != 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             par_q, par_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             tick;
    logic             accept;
    logic             load;
    logic             load_from_buf;
    logic [WIDTH-1:0] load_word;

    function automatic logic frame_parity(input logic [WIDTH-1:0] w);
        return (^w) ^ ODD_BIT;
    endfunction

    // ready_o depends only on a register, so valid_i never reaches it combinationally.
    assign ready_o = !buf_full_q;
    assign accept  = valid_i && ready_o;

    serial_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (load),
        .en_i   (state_q != S_IDLE),
        .tick_o (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; load marks the edge a new word enters the shift register
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        load_from_buf = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    state_d       = S_START;
                    load          = 1'b1;
                    load_from_buf = 1'b1;
                end else if (accept) begin
                    state_d = S_START;
                    load    = 1'b1;
                end
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick && (bit_q == LAST_BIT)) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick) begin
                    // Buffered word first; otherwise a same-edge accept chains directly.
                    if (buf_full_q) begin
                        state_d       = S_START;
                        load          = 1'b1;
                        load_from_buf = 1'b1;
                    end else if (accept) begin
                        state_d = S_START;
                        load    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        tx_o = LINE_IDLE;
        case (state_q)
            S_START:  tx_o = 1'b0;
            S_DATA:   tx_o = shift_q[0];
            S_PARITY: tx_o = par_q;
            S_STOP:   tx_o = 1'b1;
            default:  tx_o = LINE_IDLE;
        endcase
        busy_o = (state_q != S_IDLE);
    end

    // Datapath next values
    always_comb begin
        load_word  = load_from_buf ? buf_q : data_i;
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_d      = bit_q;
        if (load_from_buf) begin
            buf_full_d = 1'b0;
        end else if (accept && !load) begin
            // Accepted while a frame is shifting: park it in the buffer.
            buf_full_d = 1'b1;
            buf_d      = data_i;
        end
        if (load) begin
            shift_d = load_word;
            par_d   = frame_parity(load_word);
            bit_d   = '0;
        end else if ((state_q == S_DATA) && tick) begin
            shift_d = shift_q >> 1;
            bit_d   = (bit_q == LAST_BIT) ? '0 : bit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full_q <= 1'b0;
            bit_q      <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            bit_q      <= bit_d;
        end
    end

    // Word storage carries no reset; it is only read after a load.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        buf_q   <= buf_d;
        par_q   <= par_d;
    end

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d0, d1;
    logic       v0, v1;
    logic       r0, t0, b0;
    logic       r1, t1, b1;
    logic       r2, t2, b2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(d0), .valid_i(v0),
        .ready_o(r0), .tx_o(t0), .busy_o(b0)
    );

    serial_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
        .clk(clk), .rst_n(rst_n), .data_i(d1), .valid_i(v1),
        .ready_o(r1), .tx_o(t1), .busy_o(b1)
    );

    serial_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
        .clk(clk), .rst_n(rst_n), .data_i(d1), .valid_i(v1),
        .ready_o(r2), .tx_o(t2), .busy_o(b2)
    );

    task automatic kick0(input logic [7:0] w);
        @(negedge clk);
        d0 = w;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        repeat (3) @(negedge clk);
        tests++;
        if ({t0, r0, b0, t1, r1, b1, t2, r2, b2} !== 9'b110_110_110) begin
            fails++;
            $display("FAIL reset_outputs got %b required 110110110",
                     {t0, r0, b0, t1, r1, b1, t2, r2, b2});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tests++;
            if ({t0, r0, b0} !== 3'b110) begin
                fails++;
                $display("FAIL idle_cycle%0d tx/ready/busy got %b required 110", k, {t0, r0, b0});
            end
        end
    endtask

    task automatic test_frame_a5;
        logic [9:0] exp;
        logic [3:0] bi;
        exp = 10'b1_1010_0101_0;  // stop, A5 MSB..LSB, start
        kick0(8'hA5);
        for (int k = 0; k < 40; k++) begin
            bi = 4'(k / 4);
            tests++;
            if (t0 !== exp[bi]) begin
                fails++;
                $display("FAIL a5_tx cycle%0d got %b required %b", k, t0, exp[bi]);
            end
            tests++;
            if ({b0, r0} !== 2'b11) begin
                fails++;
                $display("FAIL a5_busy_ready cycle%0d got %b required 11", k, {b0, r0});
            end
            @(negedge clk);
        end
        tests++;
        if ({t0, b0} !== 2'b10) begin
            fails++;
            $display("FAIL a5_after_frame tx/busy got %b required 10", {t0, b0});
        end
    endtask

    task automatic test_parity;
        logic [10:0] exp_e, exp_o;
        logic [3:0]  bi;
        exp_e = 11'b1_0_1010_0101_0;  // A5 has four ones -> even parity 0
        exp_o = 11'b1_1_1010_0101_0;
        @(negedge clk);
        d1 = 8'hA5;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        for (int k = 0; k < 44; k++) begin
            bi = 4'(k / 4);
            tests++;
            if (t1 !== exp_e[bi] || b1 !== 1'b1) begin
                fails++;
                $display("FAIL parity_even cycle%0d tx/busy got %b%b required %b1", k, t1, b1, exp_e[bi]);
            end
            tests++;
            if (t2 !== exp_o[bi] || b2 !== 1'b1) begin
                fails++;
                $display("FAIL parity_odd cycle%0d tx/busy got %b%b required %b1", k, t2, b2, exp_o[bi]);
            end
            @(negedge clk);
        end
        tests++;
        if ({t1, b1, t2, b2} !== 4'b1010) begin
            fails++;
            $display("FAIL parity_after_frame got %b required 1010", {t1, b1, t2, b2});
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] fr;
        logic [3:0] bi;
        logic       acc;
        logic       exp_rdy;
        int         idx;
        @(negedge clk);
        d0  = 8'h01;
        v0  = 1'b1;
        acc = r0;
        idx = 0;
        @(negedge clk);
        for (int k = 0; k < 120; k++) begin
            fr = {1'b1, 8'(k / 40 + 1), 1'b0};
            bi = 4'((k % 40) / 4);
            tests++;
            if (t0 !== fr[bi] || b0 !== 1'b1) begin
                fails++;
                $display("FAIL b2b_tx cycle%0d tx/busy got %b%b required %b1", k, t0, b0, fr[bi]);
            end
            exp_rdy = (k == 0) || (k == 40) || (k >= 80);
            tests++;
            if (r0 !== exp_rdy) begin
                fails++;
                $display("FAIL b2b_ready cycle%0d got %b required %b", k, r0, exp_rdy);
            end
            if (acc) begin
                idx++;
                if (idx < 3) d0 = 8'(idx + 1);
                else v0 = 1'b0;
            end
            acc = v0 && r0;
            @(negedge clk);
        end
        v0 = 1'b0;
        tests++;
        if ({t0, b0, r0} !== 3'b101) begin
            fails++;
            $display("FAIL b2b_end tx/busy/ready got %b required 101", {t0, b0, r0});
        end
    endtask

    task automatic test_pulse_last_stop;
        logic [9:0] fr;
        logic [3:0] bi;
        fr = 10'b1_1100_0011_0;  // C3 framed
        kick0(8'h3C);
        repeat (39) @(negedge clk);
        tests++;
        if ({t0, b0, r0} !== 3'b111) begin
            fails++;
            $display("FAIL pulse_last_stop tx/busy/ready got %b required 111", {t0, b0, r0});
        end
        d0 = 8'hC3;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            bi = 4'(k / 4);
            tests++;
            if (t0 !== fr[bi] || b0 !== 1'b1) begin
                fails++;
                $display("FAIL pulse_frame cycle%0d tx/busy got %b%b required %b1", k, t0, b0, fr[bi]);
            end
            @(negedge clk);
        end
        tests++;
        if ({t0, b0} !== 2'b10) begin
            fails++;
            $display("FAIL pulse_after_frame tx/busy got %b required 10", {t0, b0});
        end
    endtask

    task automatic test_reset_mid;
        kick0(8'h00);
        d0 = 8'hFF;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        tests++;
        if (r0 !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_buffer_full ready got %b required 0", r0);
        end
        repeat (9) @(negedge clk);
        tests++;
        if ({t0, b0} !== 2'b01) begin
            fails++;
            $display("FAIL rstmid_data_bit tx/busy got %b required 01", {t0, b0});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({t0, r0, b0} !== 3'b110) begin
            fails++;
            $display("FAIL rstmid_async tx/ready/busy got %b required 110", {t0, r0, b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            tests++;
            if ({t0, r0, b0} !== 3'b110) begin
                fails++;
                $display("FAIL rstmid_discard cycle%0d tx/ready/busy got %b required 110", k, {t0, r0, b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity();
        test_back_to_back();
        test_pulse_last_stop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
